// File: rtl/sc_gamecontroller_param.sv
// Frogger game-flow controller: owns lives, level and house-occupancy state and
// drives one-cycle active-low strobes to the board plus status buses to the display.
module sc_gamecontroller_param #(
  parameter int NUM_HOUSES     = 5,
  parameter int MAX_LIVES      = 3,
  parameter int MAX_LEVELS     = 4,
  parameter int RESPAWN_CYCLES = 50000000,
  localparam int LW = $clog2(MAX_LIVES + 1),
  localparam int VW = $clog2(MAX_LEVELS + 1),
  localparam int HW = (NUM_HOUSES > 1) ? $clog2(NUM_HOUSES) : 1,
  localparam int RW = $clog2(RESPAWN_CYCLES + 1)
) (
  input  logic                  SC_STATEMACHINEGAME_CLOCK_50,
  input  logic                  SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic                  SC_STATEMACHINEGAME_startButton_InLow,
  input  logic                  SC_STATEMACHINEGAME_pauseButton_InLow,
  input  logic                  SC_STATEMACHINEGAME_Collision_InLow,
  input  logic                  SC_STATEMACHINEGAME_HouseArrive_InLow,
  input  logic [HW-1:0]         SC_STATEMACHINEGAME_HouseIndex_InBUS,
  output logic                  SC_STATEMACHINEGAME_StartGame_OutLow,
  output logic                  SC_STATEMACHINEGAME_LoadLevel_OutLow,
  output logic                  SC_STATEMACHINEGAME_RespawnFrog_OutLow,
  output logic                  SC_STATEMACHINEGAME_Freeze_OutLow,
  output logic                  SC_STATEMACHINEGAME_Win_OutLow,
  output logic                  SC_STATEMACHINEGAME_Lose_OutLow,
  output logic [LW-1:0]         SC_STATEMACHINEGAME_LifesCount_OutBUS,
  output logic [VW-1:0]         SC_STATEMACHINEGAME_LevelCount_OutBUS,
  output logic [NUM_HOUSES-1:0] SC_STATEMACHINEGAME_HouseMask_OutBUS,
  output logic [3:0]            SC_STATEMACHINEGAME_State_OutBUS
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_PLAY      = 4'd2,
    S_LOSELIFE  = 4'd3,
    S_RESPAWN   = 4'd4,
    S_HOUSE     = 4'd5,
    S_NEXTLEVEL = 4'd6,
    S_PAUSE     = 4'd7,
    S_WIN       = 4'd8,
    S_LOSE      = 4'd9
  } state_t;

  localparam logic [LW-1:0]         LIVES_INIT = LW'(MAX_LIVES);
  localparam logic [VW-1:0]         LAST_LEVEL = VW'(MAX_LEVELS - 1);
  localparam logic [RW-1:0]         RESP_LOAD  = RW'(RESPAWN_CYCLES - 1);
  localparam logic [NUM_HOUSES-1:0] MASK_FULL  = '1;
  localparam logic [NUM_HOUSES-1:0] MASK_ONE   = NUM_HOUSES'(1);

  state_t                  state;
  logic [LW-1:0]           lives;
  logic [VW-1:0]           level;
  logic [NUM_HOUSES-1:0]   mask;
  logic [RW-1:0]           count;
  logic [HW-1:0]           house_idx;
  logic                    start_prev;
  logic                    pause_prev;

  logic                    start_press;
  logic                    pause_press;
  logic [NUM_HOUSES-1:0]   mask_shift;
  logic                    occupied;
  logic                    bad_idx;
  logic [NUM_HOUSES-1:0]   new_mask;
  logic                    last_level;

  assign start_press = start_prev & ~SC_STATEMACHINEGAME_startButton_InLow;
  assign pause_press = pause_prev & ~SC_STATEMACHINEGAME_pauseButton_InLow;

  // Shift instead of indexing so an out-of-range index never reads past the mask.
  assign mask_shift = mask >> SC_STATEMACHINEGAME_HouseIndex_InBUS;
  assign occupied   = mask_shift[0];
  assign bad_idx    = 32'(SC_STATEMACHINEGAME_HouseIndex_InBUS) >= NUM_HOUSES;
  assign new_mask   = mask | (MASK_ONE << house_idx);
  assign last_level = (level == LAST_LEVEL);

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      state      <= S_IDLE;
      lives      <= LIVES_INIT;
      level      <= '0;
      mask       <= '0;
      count      <= '0;
      house_idx  <= '0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= SC_STATEMACHINEGAME_startButton_InLow;
      pause_prev <= SC_STATEMACHINEGAME_pauseButton_InLow;
      case (state)
        S_IDLE: begin
          if (start_press) state <= S_START;
        end
        S_START: begin
          lives <= LIVES_INIT;
          level <= '0;
          mask  <= '0;
          state <= S_PLAY;
        end
        S_PLAY: begin
          if (!SC_STATEMACHINEGAME_Collision_InLow) begin
            state <= S_LOSELIFE;
          end else if (!SC_STATEMACHINEGAME_HouseArrive_InLow) begin
            if (bad_idx || occupied) begin
              state <= S_LOSELIFE;
            end else begin
              house_idx <= SC_STATEMACHINEGAME_HouseIndex_InBUS;
              state     <= S_HOUSE;
            end
          end else if (pause_press) begin
            state <= S_PAUSE;
          end
        end
        S_LOSELIFE: begin
          if (lives <= LW'(1)) begin
            lives <= '0;
            state <= S_LOSE;
          end else begin
            lives <= lives - LW'(1);
            count <= RESP_LOAD;
            state <= S_RESPAWN;
          end
        end
        S_RESPAWN: begin
          if (count == '0) state <= S_PLAY;
          else             count <= count - RW'(1);
        end
        S_HOUSE: begin
          mask  <= new_mask;
          state <= (new_mask == MASK_FULL) ? S_NEXTLEVEL : S_PLAY;
        end
        S_NEXTLEVEL: begin
          if (last_level) begin
            state <= S_WIN;
          end else begin
            level <= level + VW'(1);
            mask  <= '0;
            state <= S_PLAY;
          end
        end
        S_PAUSE: begin
          if (pause_press) state <= S_PLAY;
        end
        S_WIN, S_LOSE: begin
          if (start_press) state <= S_START;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs: strobes depend only on registered state and counters.
  assign SC_STATEMACHINEGAME_StartGame_OutLow   = ~(state == S_START);
  assign SC_STATEMACHINEGAME_LoadLevel_OutLow   = ~((state == S_START) ||
                                                    (state == S_NEXTLEVEL && !last_level));
  assign SC_STATEMACHINEGAME_RespawnFrog_OutLow = ~((state == S_RESPAWN && count == '0) ||
                                                    (state == S_HOUSE) ||
                                                    (state == S_NEXTLEVEL && !last_level));
  assign SC_STATEMACHINEGAME_Freeze_OutLow      = ~((state == S_IDLE) || (state == S_PAUSE) ||
                                                    (state == S_RESPAWN) || (state == S_WIN) ||
                                                    (state == S_LOSE));
  assign SC_STATEMACHINEGAME_Win_OutLow         = ~(state == S_WIN);
  assign SC_STATEMACHINEGAME_Lose_OutLow        = ~(state == S_LOSE);
  assign SC_STATEMACHINEGAME_LifesCount_OutBUS  = lives;
  assign SC_STATEMACHINEGAME_LevelCount_OutBUS  = level;
  assign SC_STATEMACHINEGAME_HouseMask_OutBUS   = mask;
  assign SC_STATEMACHINEGAME_State_OutBUS       = state;

endmodule

// File: tb/tb_sc_gamecontroller_param.sv
// Directed bench for sc_gamecontroller_param: a cycle table for start, respawn and
// house filling, then hand sequences for lose, pause, win and mid-respawn reset.
module tb_sc_gamecontroller_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_b, pause_b, coll_b, arrive_b;
  logic [2:0] idx;
  logic       startgame_b, loadlevel_b, respawn_b, freeze_b, win_b, lose_b;
  logic [1:0] lives;
  logic [2:0] level;
  logic [4:0] mask;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sc_gamecontroller_param #(
    .NUM_HOUSES(5), .MAX_LIVES(3), .MAX_LEVELS(4), .RESPAWN_CYCLES(4)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50          (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh      (rst),
    .SC_STATEMACHINEGAME_startButton_InLow (start_b),
    .SC_STATEMACHINEGAME_pauseButton_InLow (pause_b),
    .SC_STATEMACHINEGAME_Collision_InLow   (coll_b),
    .SC_STATEMACHINEGAME_HouseArrive_InLow (arrive_b),
    .SC_STATEMACHINEGAME_HouseIndex_InBUS  (idx),
    .SC_STATEMACHINEGAME_StartGame_OutLow  (startgame_b),
    .SC_STATEMACHINEGAME_LoadLevel_OutLow  (loadlevel_b),
    .SC_STATEMACHINEGAME_RespawnFrog_OutLow(respawn_b),
    .SC_STATEMACHINEGAME_Freeze_OutLow     (freeze_b),
    .SC_STATEMACHINEGAME_Win_OutLow        (win_b),
    .SC_STATEMACHINEGAME_Lose_OutLow       (lose_b),
    .SC_STATEMACHINEGAME_LifesCount_OutBUS (lives),
    .SC_STATEMACHINEGAME_LevelCount_OutBUS (level),
    .SC_STATEMACHINEGAME_HouseMask_OutBUS  (mask),
    .SC_STATEMACHINEGAME_State_OutBUS      (state)
  );

  // in = {start, pause, collision, arrive}; eb = {StartGame, LoadLevel, RespawnFrog, Freeze}
  typedef struct packed {
    logic [3:0] in;
    logic [2:0] idx;
    logic [3:0] es;
    logic [1:0] el;
    logic [2:0] ev;
    logic [4:0] em;
    logic [3:0] eb;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [3:0] in, input int ix, input int es, input int el,
                              input int ev, input logic [4:0] em, input logic [3:0] eb);
    vec_t v;
    v.in  = in;
    v.idx = 3'(ix);
    v.es  = 4'(es);
    v.el  = 2'(el);
    v.ev  = 3'(ev);
    v.em  = em;
    v.eb  = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int es, input int el, input int ev,
                         input logic [4:0] em, input logic [3:0] eb);
    chk($sformatf("%s.state", nm), 32'(state), 32'(es));
    chk($sformatf("%s.lives", nm), 32'(lives), 32'(el));
    chk($sformatf("%s.level", nm), 32'(level), 32'(ev));
    chk($sformatf("%s.mask",  nm), 32'(mask),  32'(em));
    chk($sformatf("%s.strb",  nm), 32'({startgame_b, loadlevel_b, respawn_b, freeze_b}), 32'(eb));
    chk($sformatf("%s.win",   nm), 32'(win_b),  (es == 8) ? 32'd0 : 32'd1);
    chk($sformatf("%s.lose",  nm), 32'(lose_b), (es == 9) ? 32'd0 : 32'd1);
  endtask

  task automatic step(input logic [3:0] in, input int ix);
    {start_b, pause_b, coll_b, arrive_b} = in;
    idx = 3'(ix);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_level(input int lv, input int el);
    for (int h = 0; h < 5; h++) begin
      step(4'b1110, h);
      chk_all($sformatf("fill%0d_%0d_house", lv, h), 5, el, lv, 5'((1 << h) - 1), 4'b1101);
      step(4'b1111, 0);
      chk_all($sformatf("fill%0d_%0d_leave", lv, h), (h < 4) ? 2 : 6, el, lv,
              5'((1 << (h + 1)) - 1), (h < 4) ? 4'b1111 : ((lv < 3) ? 4'b1001 : 4'b1111));
    end
    step(4'b1111, 0);
    if (lv < 3) chk_all($sformatf("next%0d", lv), 2, el, lv + 1, 5'b00000, 4'b1111);
    else        chk_all("win", 8, el, 3, 5'b11111, 4'b1110);
  endtask

  initial begin
    tbl[0]  = mk(4'b0111, 0, 1, 3, 0, 5'b00000, 4'b0011);
    tbl[1]  = mk(4'b0111, 0, 2, 3, 0, 5'b00000, 4'b1111);
    tbl[2]  = mk(4'b0111, 0, 2, 3, 0, 5'b00000, 4'b1111);
    tbl[3]  = mk(4'b1111, 0, 2, 3, 0, 5'b00000, 4'b1111);
    tbl[4]  = mk(4'b1101, 0, 3, 3, 0, 5'b00000, 4'b1111);
    tbl[5]  = mk(4'b1111, 0, 4, 2, 0, 5'b00000, 4'b1110);
    tbl[6]  = mk(4'b1100, 0, 4, 2, 0, 5'b00000, 4'b1110);
    tbl[7]  = mk(4'b1111, 0, 4, 2, 0, 5'b00000, 4'b1110);
    tbl[8]  = mk(4'b1111, 0, 4, 2, 0, 5'b00000, 4'b1100);
    tbl[9]  = mk(4'b1111, 0, 2, 2, 0, 5'b00000, 4'b1111);
    tbl[10] = mk(4'b1110, 0, 5, 2, 0, 5'b00000, 4'b1101);
    tbl[11] = mk(4'b1111, 0, 2, 2, 0, 5'b00001, 4'b1111);
    tbl[12] = mk(4'b1110, 1, 5, 2, 0, 5'b00001, 4'b1101);
    tbl[13] = mk(4'b1111, 0, 2, 2, 0, 5'b00011, 4'b1111);
    tbl[14] = mk(4'b1110, 2, 5, 2, 0, 5'b00011, 4'b1101);
    tbl[15] = mk(4'b1111, 0, 2, 2, 0, 5'b00111, 4'b1111);
    tbl[16] = mk(4'b1110, 3, 5, 2, 0, 5'b00111, 4'b1101);
    tbl[17] = mk(4'b1111, 0, 2, 2, 0, 5'b01111, 4'b1111);
    tbl[18] = mk(4'b1110, 4, 5, 2, 0, 5'b01111, 4'b1101);
    tbl[19] = mk(4'b1111, 0, 6, 2, 0, 5'b11111, 4'b1001);
    tbl[20] = mk(4'b1111, 0, 2, 2, 1, 5'b00000, 4'b1111);
    tbl[21] = mk(4'b1110, 0, 5, 2, 1, 5'b00000, 4'b1101);
    tbl[22] = mk(4'b1111, 0, 2, 2, 1, 5'b00001, 4'b1111);
    tbl[23] = mk(4'b1110, 0, 3, 2, 1, 5'b00001, 4'b1111);
    tbl[24] = mk(4'b1111, 0, 4, 1, 1, 5'b00001, 4'b1110);
    tbl[25] = mk(4'b1111, 0, 4, 1, 1, 5'b00001, 4'b1110);
    tbl[26] = mk(4'b1111, 0, 4, 1, 1, 5'b00001, 4'b1110);
    tbl[27] = mk(4'b1111, 0, 4, 1, 1, 5'b00001, 4'b1100);
    tbl[28] = mk(4'b1111, 0, 2, 1, 1, 5'b00001, 4'b1111);

    rst = 1'b1;
    {start_b, pause_b, coll_b, arrive_b} = 4'b1111;
    idx = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 3, 0, 5'b00000, 4'b1110);
    rst = 1'b0;
    step(4'b1111, 0);
    chk_all("idle", 0, 3, 0, 5'b00000, 4'b1110);

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].in, int'(tbl[i].idx));
      chk_all($sformatf("vec%0d", i), int'(tbl[i].es), int'(tbl[i].el), int'(tbl[i].ev),
              tbl[i].em, tbl[i].eb);
    end

    // Out-of-range house with one life left ends the game; LOSE ignores collisions.
    step(4'b1110, 5);
    chk_all("badidx", 3, 1, 1, 5'b00001, 4'b1111);
    step(4'b1111, 0);
    chk_all("lose", 9, 0, 1, 5'b00001, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      step(4'b1101, 0);
      chk_all($sformatf("lose_hold%0d", i), 9, 0, 1, 5'b00001, 4'b1110);
    end
    step(4'b0111, 0);
    chk_all("restart1", 1, 0, 1, 5'b00001, 4'b0011);
    step(4'b1111, 0);
    chk_all("restart1_play", 2, 3, 0, 5'b00000, 4'b1111);

    for (int k = 0; k < 3; k++) begin
      step(4'b1101, 0);
      chk_all($sformatf("coll%0d", k), 3, 3 - k, 0, 5'b00000, 4'b1111);
      step(4'b1111, 0);
      if (k < 2) begin
        chk_all($sformatf("coll%0d_resp", k), 4, 2 - k, 0, 5'b00000, 4'b1110);
        repeat (4) step(4'b1111, 0);
        chk_all($sformatf("coll%0d_back", k), 2, 2 - k, 0, 5'b00000, 4'b1111);
      end else begin
        chk_all("coll_lose", 9, 0, 0, 5'b00000, 4'b1110);
      end
    end
    step(4'b0111, 0);
    step(4'b1111, 0);
    chk_all("restart2", 2, 3, 0, 5'b00000, 4'b1111);

    // Collision and arrival together: collision wins, mask untouched.
    step(4'b1100, 0);
    chk_all("simul", 3, 3, 0, 5'b00000, 4'b1111);
    step(4'b1111, 0);
    chk_all("simul_resp", 4, 2, 0, 5'b00000, 4'b1110);
    repeat (4) step(4'b1111, 0);
    chk_all("simul_back", 2, 2, 0, 5'b00000, 4'b1111);

    step(4'b1011, 0);
    chk_all("pause", 7, 2, 0, 5'b00000, 4'b1110);
    step(4'b1001, 0);
    chk_all("pause_held", 7, 2, 0, 5'b00000, 4'b1110);
    step(4'b1111, 0);
    chk_all("pause_rel", 7, 2, 0, 5'b00000, 4'b1110);
    step(4'b0011, 0);
    chk_all("unpause", 2, 2, 0, 5'b00000, 4'b1111);
    step(4'b1111, 0);
    chk_all("unpause_play", 2, 2, 0, 5'b00000, 4'b1111);

    for (int lv = 0; lv < 4; lv++) fill_level(lv, 2);
    step(4'b1101, 0);
    chk_all("win_hold", 8, 2, 3, 5'b11111, 4'b1110);
    step(4'b0111, 0);
    chk_all("win_restart", 1, 2, 3, 5'b11111, 4'b0011);
    step(4'b1111, 0);
    chk_all("win_play", 2, 3, 0, 5'b00000, 4'b1111);

    // Reset lands mid-respawn (counter at 2), between clock edges.
    step(4'b1101, 0);
    step(4'b1111, 0);
    step(4'b1111, 0);
    chk_all("pre_rst", 4, 2, 0, 5'b00000, 4'b1110);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 3, 0, 5'b00000, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("rst_hold%0d", i), 0, 3, 0, 5'b00000, 4'b1110);
    end
    rst = 1'b0;
    repeat (3) step(4'b1111, 0);
    chk_all("post_rst", 0, 3, 0, 5'b00000, 4'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_gamecontroller_param.md
Name: sc_gamecontroller_param

Overview:
- Parametrised successor to the Frogger game-flow state machine.
- Holds the lives counter, level counter and house-occupancy mask internally, so no external comparators are needed.
- Adds pause, a timed respawn window, restart from win/lose, and occupied-house detection.
- Sits between the frog/collision logic and the board/level loaders.
- Drives one-cycle active-low strobes to the board, plus status buses to the display.

Parameters:
- NUM_HOUSES, 5: number of goal houses; range 1..16.
- MAX_LIVES, 3: lives loaded at game start; range 1..15.
- MAX_LEVELS, 4: levels to clear before a win; range 1..15.
- RESPAWN_CYCLES, 50000000: cycles spent in RESPAWN after a life is lost; minimum 1.
- Derived: LW = $clog2(MAX_LIVES+1), VW = $clog2(MAX_LEVELS+1), HW = $clog2(NUM_HOUSES) (minimum 1), RW = $clog2(RESPAWN_CYCLES+1).

Ports:
- SC_STATEMACHINEGAME_CLOCK_50, in, 1: system clock.
- SC_STATEMACHINEGAME_RESET_InHigh, in, 1: reset, asynchronous, active-high.
- SC_STATEMACHINEGAME_startButton_InLow, in, 1: start/restart button, synchronous, active-low.
- SC_STATEMACHINEGAME_pauseButton_InLow, in, 1: pause toggle button, active-low.
- SC_STATEMACHINEGAME_Collision_InLow, in, 1: frog hit a car or water, level-sensitive.
- SC_STATEMACHINEGAME_HouseArrive_InLow, in, 1: frog reached the goal row this cycle.
- SC_STATEMACHINEGAME_HouseIndex_InBUS, in, HW: house reached; qualified by HouseArrive.
- SC_STATEMACHINEGAME_StartGame_OutLow, out, 1: one-cycle strobe that resets the board.
- SC_STATEMACHINEGAME_LoadLevel_OutLow, out, 1: one-cycle strobe that loads the level in LevelCount.
- SC_STATEMACHINEGAME_RespawnFrog_OutLow, out, 1: one-cycle strobe that returns the frog to the start row.
- SC_STATEMACHINEGAME_Freeze_OutLow, out, 1: low while obstacles must stop (PAUSE, RESPAWN, WIN, LOSE, IDLE).
- SC_STATEMACHINEGAME_Win_OutLow, out, 1: low in WIN.
- SC_STATEMACHINEGAME_Lose_OutLow, out, 1: low in LOSE.
- SC_STATEMACHINEGAME_LifesCount_OutBUS, out, LW: remaining lives.
- SC_STATEMACHINEGAME_LevelCount_OutBUS, out, VW: current level, 0-based.
- SC_STATEMACHINEGAME_HouseMask_OutBUS, out, NUM_HOUSES: occupied houses.
- SC_STATEMACHINEGAME_State_OutBUS, out, 4: state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, START=1, PLAY=2, LOSELIFE=3, RESPAWN=4, HOUSE=5, NEXTLEVEL=6, PAUSE=7, WIN=8, LOSE=9. Encodings 10..15 go to IDLE on the next clock.
- Reset, asynchronous and valid at any time including mid-game:
  - State = IDLE.
  - Lives = MAX_LIVES, level = 0, mask = 0, respawn counter = 0.
  - Button history registers = 1.
  - All _OutLow outputs = 1 except Freeze = 0.
- Buttons: a press is a falling edge, i.e. previous registered sample 1 and current sample 0. At most one action per press. The press is seen in the cycle the input first reads 0.
- Outputs are Moore, decoded from the state register only. Counters and mask are registered and update on the clock edge that leaves the listed state.
- IDLE: start press -> START.
- START: StartGame = 0 and LoadLevel = 0 for one cycle; lives = MAX_LIVES, level = 0, mask = 0; -> PLAY.
- PLAY, evaluated in priority order:
  1. Collision = 0 -> LOSELIFE.
  2. HouseArrive = 0 with mask[idx] = 1, or idx >= NUM_HOUSES -> LOSELIFE.
  3. HouseArrive = 0 with a free house -> HOUSE.
  4. Pause press -> PAUSE.
  5. Otherwise stay in PLAY.
- LOSELIFE, one cycle:
  - If lives == 1: lives -> 0, -> LOSE.
  - Else: lives -= 1, counter = RESPAWN_CYCLES - 1, -> RESPAWN.
- RESPAWN:
  - Freeze = 0; Collision and HouseArrive are ignored.
  - Counter decrements each cycle. At 0: RespawnFrog = 0 for that cycle, -> PLAY.
  - With RESPAWN_CYCLES = 1, RESPAWN lasts exactly 1 cycle.
- HOUSE, one cycle: mask[idx] set; RespawnFrog = 0.
  - If the new mask is all ones -> NEXTLEVEL.
  - Else -> PLAY.
- NEXTLEVEL, one cycle:
  - If level == MAX_LEVELS - 1 -> WIN, with level unchanged.
  - Else: level += 1, mask = 0, LoadLevel = 0, RespawnFrog = 0, -> PLAY.
- PAUSE: Freeze = 0; all game inputs ignored. A pause press returns to PLAY; the same-cycle start press is ignored.
- WIN / LOSE: hold the state with counters frozen; a start press -> START.
- Simultaneous Collision and HouseArrive in PLAY: collision wins and the mask is not updated.
- Counter widths never over- or underflow: lives never decrements below 0 and level never exceeds MAX_LEVELS - 1.
- Latency: input event in PLAY to the state change is 1 clock. The lives/level/mask update is visible 1 clock after that.

Test Plan:
1. Reset, then start pulled low for 3 cycles: exactly one START. Lives = 3, level = 0, mask = 0, StartGame low for exactly 1 cycle, then PLAY.
2. PLAY with RESPAWN_CYCLES = 4, Collision low for 1 cycle: LOSELIFE, then 4 cycles in RESPAWN with Freeze low, RespawnFrog strobe on the last one. Lives = 2, back in PLAY.
3. Houses 0..4 filled, then the same house re-entered: each fill sets its mask bit. The fifth fill leads to NEXTLEVEL, level = 1, mask = 0, LoadLevel strobe. Re-entering an occupied house costs 1 life.
4. Three consecutive collisions with MAX_LIVES = 3: the third reaches LOSE with lives = 0 and Lose low. Collisions during LOSE have no effect. A start press restarts with lives = 3.
5. Clear level MAX_LEVELS - 1 = 3: WIN, Win low, level stays 3. Pause press in PLAY: PAUSE with Freeze low, and Collision is ignored. Second pause press returns to PLAY.
6. Assert reset while in RESPAWN with counter = 2: IDLE immediately, all counters at reset values, no RespawnFrog strobe.
